reg_file: RTL
=============

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width.
REQ-002 SHALL have parameter ADDR_W, default 5, register index width; the file SHALL hold 2**ADDR_W entries.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 SHALL have port wb_regwrite  input  1  writeback write enable from the WB stage.
REQ-006 SHALL have port wb_rd  input  ADDR_W  writeback destination index.
REQ-007 SHALL have port wb_result  input  DATA_W  writeback data.
REQ-008 SHALL have port rd_en  input  1  read request from the decode stage.
REQ-009 SHALL have port stall  input  1  decode stall; holds the read outputs.
REQ-010 SHALL have ports rs1_addr, rs2_addr  input  ADDR_W  source indices.
REQ-011 SHALL have ports rs1_data, rs2_data  output  DATA_W  registered read data.
REQ-012 SHALL have port issue_en  input  1  an instruction with a destination leaves decode.
REQ-013 SHALL have port issue_rd  input  ADDR_W  destination of the issuing instruction.
REQ-014 SHALL have ports rs1_busy, rs2_busy  output  1  source has an outstanding write.

Function
REQ-015 Write: at a rising clk with wb_regwrite=1 and wb_rd!=0, entry wb_rd SHALL take wb_result.
REQ-016 Entry 0 SHALL never be written and SHALL always read as 0.
REQ-017 Read: at a rising clk with rd_en=1 and stall=0, rsN_data SHALL take entry rsN_addr; one-cycle latency.
REQ-018 With rd_en=0 or stall=1, rsN_data SHALL hold its value; stall SHALL take priority over rd_en.
REQ-019 Bypass: if a capturing read and an accepted write (REQ-015) target the same nonzero index in the same cycle, rsN_data SHALL take wb_result, not the old entry.
REQ-020 rs1 and rs2 SHALL be independent; equal addresses SHALL return identical data.
REQ-021 Scoreboard: one pending bit per index 1..2**ADDR_W-1; issue_en=1 with issue_rd!=0 SHALL set pending[issue_rd].
REQ-022 An accepted write SHALL clear pending[wb_rd].
REQ-023 Same cycle, same index, set and clear: set SHALL win.
REQ-024 rsN_busy SHALL be combinational: pending[rsN_addr] AND NOT (accepted write to rsN_addr this cycle); it SHALL be 0 for index 0.
REQ-025 A writeback to an index that is not pending SHALL still write the entry and leave pending at 0.

Reset
REQ-026 On reset=0, all entries, rs1_data, rs2_data and all pending bits SHALL go to 0 immediately, independent of clk.
REQ-027 Reset SHALL override any write, read or issue that is in progress; no update SHALL occur while reset=0.
REQ-028 The first rising clk after reset=1 SHALL operate normally.

Configuration
REQ-029 Macro REG_FILE_SCOREBOARD_EN SHALL compile in the pending-bit scoreboard (REQ-021..REQ-025).
REQ-030 Without REG_FILE_SCOREBOARD_EN:
- issue_en and issue_rd SHALL be ignored.
- rs1_busy and rs2_busy SHALL be tied to 0.
- No pending storage SHALL exist.
- The port list SHALL be unchanged.

Structure
REQ-031 The DATA_W and ADDR_W defaults and the x0 index constant SHALL live in the shared pipeline package.
REQ-032 The scoreboard SHALL be the sub-module reg_file_scoreboard, instantiated only under REG_FILE_SCOREBOARD_EN; storage and bypass SHALL stay in reg_file.

Verification
REQ-033 Write x5=0xDEADBEEF, next cycle read rs1_addr=5 -> rs1_data=0xDEADBEEF one cycle later.
REQ-034 Write x0=0x12345678, then read rs1_addr=0, rs2_addr=0 -> both 0x00000000.
REQ-035 Same cycle: write x7=0xA5A5A5A5 and read rs2_addr=7 (old value 0x1) -> rs2_data=0xA5A5A5A5.
REQ-036 Read x3=0x11 then assert stall=1 for 3 cycles while writing x3=0x22 -> rs1_data stays 0x11 until the stall is released.
REQ-037 With REG_FILE_SCOREBOARD_EN:
- issue_rd=9 -> rs1_busy=1 for rs1_addr=9.
- Same cycle as writeback to 9 -> rs1_busy=0.
- issue_rd=9 together with writeback to 9 -> pending stays 1.
REQ-038 Assert reset=0 mid-write of x4=0xFF (no clk edge) -> all outputs and entries read 0 after release.

Source files
------------

// File: rtl/reg_file_pkg.sv
// -----------------------------------------------------------------------------
// reg_file_pkg
// Shared pipeline package for the register file slice.
//   REG_DATA_W : default register width
//   REG_ADDR_W : default register index width (file holds 2**REG_ADDR_W entries)
//   X0_IDX     : hard-wired zero register index
// -----------------------------------------------------------------------------
package reg_file_pkg;

    localparam int REG_DATA_W = 32;
    localparam int REG_ADDR_W = 5;
    localparam int X0_IDX     = 0;

endpackage : reg_file_pkg

// File: rtl/reg_file_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_file_scoreboard
// Pending-write tracker: one bit per register index 1..2**ADDR_W-1.
// Ports:
//   clk, reset        : clock, asynchronous active-low reset
//   i_issue_en/rd     : an issuing instruction that will write i_issue_rd
//   i_wr_accept/wb_rd : a writeback accepted by the register file this cycle
//   i_rs1/2_addr      : source indices being looked up
//   o_rs1/2_busy      : combinational busy flags for the sources
// -----------------------------------------------------------------------------
module reg_file_scoreboard
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_issue_en,
    input  logic [ADDR_W-1:0] i_issue_rd,
    input  logic              i_wr_accept,
    input  logic [ADDR_W-1:0] i_wb_rd,
    input  logic [ADDR_W-1:0] i_rs1_addr,
    input  logic [ADDR_W-1:0] i_rs2_addr,
    output logic              o_rs1_busy,
    output logic              o_rs2_busy
);

    localparam int                DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] X0    = ADDR_W'(X0_IDX);

    // Bit 0 exists only to keep indexing uniform; it is never set.
    logic [DEPTH-1:0] r_pending;
    logic [DEPTH-1:0] w_pending_next;
    logic             w_set;

    // Next pending vector: clear first, then set, so a same-index set wins.
    always_comb begin
        w_pending_next = r_pending;
        w_set          = i_issue_en && (i_issue_rd != X0);
        if (i_wr_accept) begin
            w_pending_next[i_wb_rd] = 1'b0;
        end else begin
            w_pending_next = w_pending_next;
        end
        if (w_set) begin
            w_pending_next[i_issue_rd] = 1'b1;
        end else begin
            w_pending_next = w_pending_next;
        end
        w_pending_next[0] = 1'b0;
    end

    // Pending bit storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_next;
        end
    end

    // Busy lookup: a write completing this cycle already resolves the hazard.
    always_comb begin
        o_rs1_busy = 1'b0;
        o_rs2_busy = 1'b0;
        if (i_rs1_addr != X0) begin
            o_rs1_busy = r_pending[i_rs1_addr] && !(i_wr_accept && (i_wb_rd == i_rs1_addr));
        end else begin
            o_rs1_busy = 1'b0;
        end
        if (i_rs2_addr != X0) begin
            o_rs2_busy = r_pending[i_rs2_addr] && !(i_wr_accept && (i_wb_rd == i_rs2_addr));
        end else begin
            o_rs2_busy = 1'b0;
        end
    end

endmodule : reg_file_scoreboard

// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file
// Two-read / one-write register file with registered read ports, writeback
// bypass, hard-wired x0 and an optional pending-write scoreboard.
// Configuration macro: REG_FILE_SCOREBOARD_EN (compiles in the scoreboard;
// without it issue_en/issue_rd are ignored and rs1_busy/rs2_busy are 0).
// Ports:
//   clk, reset                       : clock, asynchronous active-low reset
//   wb_regwrite, wb_rd, wb_result    : writeback port
//   rd_en, stall                     : read capture request / hold
//   rs1_addr, rs2_addr               : source indices
//   rs1_data, rs2_data               : registered read data
//   issue_en, issue_rd               : destination being issued from decode
//   rs1_busy, rs2_busy               : source has an outstanding write
// -----------------------------------------------------------------------------
module reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_regwrite,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_result,
    input  logic              rd_en,
    input  logic              stall,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_rd,
    output logic              rs1_busy,
    output logic              rs2_busy
);

    localparam int                DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] X0    = ADDR_W'(X0_IDX);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rs1_data;
    logic [DATA_W-1:0] r_rs2_data;
    logic [DATA_W-1:0] w_rs1_next;
    logic [DATA_W-1:0] w_rs2_next;
    logic              w_wr_accept;
    logic              w_rd_capture;

    assign w_wr_accept  = wb_regwrite && (wb_rd != X0);
    assign w_rd_capture = rd_en && !stall;
    assign rs1_data     = r_rs1_data;
    assign rs2_data     = r_rs2_data;

    // Entry storage; x0 is never written so it stays at its reset value of 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_accept) begin
            r_mem[wb_rd] <= wb_result;
        end else begin
            r_mem <= r_mem;
        end
    end

    // Read mux with writeback bypass; x0 forced to zero.
    always_comb begin
        w_rs1_next = r_mem[rs1_addr];
        w_rs2_next = r_mem[rs2_addr];
        if (rs1_addr == X0) begin
            w_rs1_next = '0;
        end else if (w_wr_accept && (wb_rd == rs1_addr)) begin
            w_rs1_next = wb_result;
        end else begin
            w_rs1_next = r_mem[rs1_addr];
        end
        if (rs2_addr == X0) begin
            w_rs2_next = '0;
        end else if (w_wr_accept && (wb_rd == rs2_addr)) begin
            w_rs2_next = wb_result;
        end else begin
            w_rs2_next = r_mem[rs2_addr];
        end
    end

    // Registered read ports; stall holds them regardless of rd_en.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rs1_data <= '0;
            r_rs2_data <= '0;
        end else if (w_rd_capture) begin
            r_rs1_data <= w_rs1_next;
            r_rs2_data <= w_rs2_next;
        end else begin
            r_rs1_data <= r_rs1_data;
            r_rs2_data <= r_rs2_data;
        end
    end

`ifdef REG_FILE_SCOREBOARD_EN
    reg_file_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .i_issue_en  (issue_en),
        .i_issue_rd  (issue_rd),
        .i_wr_accept (w_wr_accept),
        .i_wb_rd     (wb_rd),
        .i_rs1_addr  (rs1_addr),
        .i_rs2_addr  (rs2_addr),
        .o_rs1_busy  (rs1_busy),
        .o_rs2_busy  (rs2_busy)
    );
`else
    // Issue inputs have no consumer in this build.
    logic w_unused_issue;
    assign w_unused_issue = ^{issue_en, issue_rd};
    assign rs1_busy       = 1'b0;
    assign rs2_busy       = 1'b0;
`endif

endmodule : reg_file
